// File: rtl/spi_mem_loader.sv
// Bit-per-clock serial loader/readback port for the processor memories.
// Optional write bursts with address wrap: define SPI_MEM_LOADER_BURST_EN.
module spi_mem_loader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int NUM_CH = 2,
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] cs_n,
   input  logic              mosi,
   input  logic              lock,
   output logic              miso,
   output logic              wr_en,
   output logic [CH_W-1:0]   wr_ch,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_en,
   output logic [CH_W-1:0]   rd_ch,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              frame_err
);

   localparam int CNT_W = $clog2(ADDR_W + DATA_W + 2);
   localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(ADDR_W + DATA_W);
   localparam logic [CNT_W-1:0] LAST_RD   = CNT_W'(ADDR_W + DATA_W + 1);
`ifdef SPI_MEM_LOADER_BURST_EN
   localparam logic [CNT_W-1:0] FIRST_DATA = CNT_W'(ADDR_W + 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CMD   = 3'd1,
      S_ADDR  = 3'd2,
      S_WDATA = 3'd3,
      S_RTURN = 3'd4,
      S_RDATA = 3'd5,
      S_WAIT  = 3'd6
   } state_t;

   // 0: no select low, 1: exactly one low, 2: more than one low
   function automatic logic [1:0] low_count(input logic [NUM_CH-1:0] v);
      logic seen_one;
      logic seen_two;
      seen_one = 1'b0;
      seen_two = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!v[i]) begin
            seen_two = seen_two | seen_one;
            seen_one = 1'b1;
         end
      end
      return seen_two ? 2'd2 : (seen_one ? 2'd1 : 2'd0);
   endfunction

   function automatic logic [CH_W-1:0] low_index(input logic [NUM_CH-1:0] v);
      logic [CH_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!v[i]) begin
            idx = CH_W'(i);
         end
      end
      return idx;
   endfunction

   state_t state_q, state_d;
   logic              cmd_q, cmd_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] wsh_q, wsh_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              busy_q, busy_d;
   logic              frame_err_q, frame_err_d;
   logic              wr_en_q, wr_en_d;
   logic [CH_W-1:0]   wr_ch_q, wr_ch_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              rd_en_q, rd_en_d;
   logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
`ifdef SPI_MEM_LOADER_BURST_EN
   logic              wrote_q, wrote_d;
`endif

   logic [1:0]        low_cnt_s;
   logic [CH_W-1:0]   low_ch_s;
   logic              sel_hi_s;
   logic              all_hi_s;
   logic [ADDR_W-1:0] addr_next_s;
   logic [DATA_W-1:0] wsh_next_s;

   assign low_cnt_s   = low_count(cs_n);
   assign low_ch_s    = low_index(cs_n);
   assign sel_hi_s    = cs_n[ch_q];
   assign all_hi_s    = &cs_n;
   assign addr_next_s = ADDR_W'({addr_q, mosi});
   assign wsh_next_s  = DATA_W'({wsh_q, mosi});

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode; cs_n on the final data edge is ignored so that edge still completes
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!lock && low_cnt_s == 2'd1) begin
               state_d = S_ADDR;
            end else if (!lock && low_cnt_s == 2'd2) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ADDR: begin
            if (sel_hi_s) begin
               state_d = S_IDLE;
            end else if (cnt_q == LAST_ADDR) begin
               state_d = cmd_q ? S_WDATA : S_RTURN;
            end else begin
               state_d = S_ADDR;
            end
         end
         S_WDATA: begin
            if (cnt_q == LAST_DATA) begin
`ifdef SPI_MEM_LOADER_BURST_EN
               state_d = S_WDATA;
`else
               state_d = S_WAIT;
`endif
            end else if (sel_hi_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WDATA;
            end
         end
         S_RTURN: begin
            if (sel_hi_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RDATA;
            end
         end
         S_RDATA: begin
            if (cnt_q == LAST_RD) begin
               state_d = S_WAIT;
            end else if (sel_hi_s && cnt_q != LAST_DATA) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RDATA;
            end
         end
         S_WAIT: begin
            if (all_hi_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      cmd_d       = cmd_q;
      ch_d        = ch_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q + CNT_W'(1);
      wsh_d       = wsh_q;
      sh_d        = '0;
      busy_d      = (state_d != S_IDLE);
      frame_err_d = 1'b0;
      wr_en_d     = 1'b0;
      wr_ch_d     = wr_ch_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      rd_en_d     = 1'b0;
      rd_ch_d     = rd_ch_q;
      rd_addr_d   = rd_addr_q;
`ifdef SPI_MEM_LOADER_BURST_EN
      wrote_d     = wrote_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!lock && low_cnt_s == 2'd1) begin
               cmd_d  = mosi;
               ch_d   = low_ch_s;
               cnt_d  = CNT_W'(1);
               addr_d = '0;
               wsh_d  = '0;
`ifdef SPI_MEM_LOADER_BURST_EN
               wrote_d = 1'b0;
`endif
            end else begin
               cnt_d       = '0;
               frame_err_d = !lock && (low_cnt_s == 2'd2);
            end
         end
         S_ADDR: begin
            if (sel_hi_s) begin
               frame_err_d = 1'b1;
            end else begin
               addr_d = addr_next_s;
               if (cnt_q == LAST_ADDR && !cmd_q) begin
                  rd_en_d   = 1'b1;
                  rd_ch_d   = ch_q;
                  rd_addr_d = addr_next_s;
               end else begin
                  rd_en_d = 1'b0;
               end
            end
         end
         S_WDATA: begin
            if (cnt_q == LAST_DATA) begin
               wr_en_d   = 1'b1;
               wr_ch_d   = ch_q;
               wr_addr_d = addr_q;
               wr_data_d = wsh_next_s;
               wsh_d     = '0;
`ifdef SPI_MEM_LOADER_BURST_EN
               addr_d  = addr_q + ADDR_W'(1);
               cnt_d   = FIRST_DATA;
               wrote_d = 1'b1;
`endif
            end else if (sel_hi_s) begin
`ifdef SPI_MEM_LOADER_BURST_EN
               frame_err_d = !wrote_q;
`else
               frame_err_d = 1'b1;
`endif
            end else begin
               wsh_d = wsh_next_s;
            end
         end
         S_RTURN: begin
            if (sel_hi_s) begin
               frame_err_d = 1'b1;
            end else begin
               sh_d = rd_data;
            end
         end
         S_RDATA: begin
            if (cnt_q == LAST_RD) begin
               sh_d = '0;
            end else if (sel_hi_s && cnt_q != LAST_DATA) begin
               frame_err_d = 1'b1;
            end else begin
               sh_d = DATA_W'({sh_q, 1'b0});
            end
         end
         S_WAIT: begin
            cnt_d = '0;
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q       <= 1'b0;
         ch_q        <= '0;
         addr_q      <= '0;
         cnt_q       <= '0;
         wsh_q       <= '0;
         sh_q        <= '0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_ch_q     <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_en_q     <= 1'b0;
         rd_ch_q     <= '0;
         rd_addr_q   <= '0;
`ifdef SPI_MEM_LOADER_BURST_EN
         wrote_q     <= 1'b0;
`endif
      end else begin
         cmd_q       <= cmd_d;
         ch_q        <= ch_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         wsh_q       <= wsh_d;
         sh_q        <= sh_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
         wr_en_q     <= wr_en_d;
         wr_ch_q     <= wr_ch_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_en_q     <= rd_en_d;
         rd_ch_q     <= rd_ch_d;
         rd_addr_q   <= rd_addr_d;
`ifdef SPI_MEM_LOADER_BURST_EN
         wrote_q     <= wrote_d;
`endif
      end
   end

   assign miso      = sh_q[DATA_W-1];
   assign busy      = busy_q;
   assign frame_err = frame_err_q;
   assign wr_en     = wr_en_q;
   assign wr_ch     = wr_ch_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign rd_en     = rd_en_q;
   assign rd_ch     = rd_ch_q;
   assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_spi_mem_loader.sv
// Directed bench for spi_mem_loader (DATA_W=8, ADDR_W=4, NUM_CH=2).
module tb_spi_mem_loader;

   logic       clk;
   logic       rst;
   logic [1:0] cs_n;
   logic       mosi;
   logic       lock;
   logic       miso;
   logic       wr_en;
   logic [0:0] wr_ch;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [0:0] rd_ch;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy;
   logic       frame_err;

   int err_cnt = 0;
   int chk_cnt = 0;

`ifdef SPI_MEM_LOADER_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   spi_mem_loader #(.DATA_W(8), .ADDR_W(4), .NUM_CH(2)) dut (
      .clk(clk), .rst(rst), .cs_n(cs_n), .mosi(mosi), .lock(lock),
      .miso(miso), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
      .rd_data(rd_data), .busy(busy), .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one bit, then return just after the sampling edge
   task automatic drive(input logic [1:0] cs, input logic b);
      @(negedge clk);
      cs_n = cs;
      mosi = b;
      @(posedge clk);
      #1;
   endtask

   task automatic write_frame(input string tag, input logic [1:0] cs, input logic exp_ch,
                              input logic [3:0] a, input logic [7:0] d, input logic rel_last);
      logic [12:0] bits;
      bits = {1'b1, a, d};
      for (int e = 0; e <= 12; e++) begin
         drive((e == 12 && rel_last) ? 2'b11 : cs, bits[12-e]);
         check_eq({tag, "_wr_en"}, wr_en, (e == 12));
         if (e == 0) check_eq({tag, "_busy_rise"}, busy, 1'b1);
      end
      check_eq({tag, "_wr_ch"}, wr_ch, exp_ch);
      check_eq({tag, "_wr_addr"}, wr_addr, a);
      check_eq({tag, "_wr_data"}, wr_data, d);
      check_eq({tag, "_err"}, frame_err, 1'b0);
      drive(2'b11, 1'b0);
      check_eq({tag, "_busy_fall"}, busy, 1'b0);
      check_eq({tag, "_err_end"}, frame_err, 1'b0);
      check_eq({tag, "_wr_en_end"}, wr_en, 1'b0);
   endtask

   initial begin
      logic [4:0]  rbits;
      logic [7:0]  rval;
      logic [20:0] bbits;
      logic [12:0] abits;

      rst = 1'b1; cs_n = 2'b11; mosi = 1'b0; lock = 1'b0; rd_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_miso", miso, 1'b0);
      check_eq("rst_wr_en", wr_en, 1'b0);
      check_eq("rst_rd_en", rd_en, 1'b0);
      check_eq("rst_err", frame_err, 1'b0);
      check_eq("rst_wr", {wr_ch, wr_addr, wr_data}, 13'h0);
      check_eq("rst_rd", {rd_ch, rd_addr}, 5'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(2'b11, 1'b0);

      // Write ch0 addr 5 data 0xA3
      write_frame("wr1", 2'b10, 1'b0, 4'd5, 8'hA3, 1'b0);

      // Read ch1 addr 3, memory returns 0x5C
      rd_data = 8'h5C;
      rbits = 5'b0_0011;
      rval = 8'h5C;
      for (int e = 0; e <= 12; e++) begin
         drive(2'b01, (e <= 4) ? rbits[4-e] : 1'b0);
         check_eq("rd_en", rd_en, (e == 4));
         if (e == 4) begin
            check_eq("rd_ch", rd_ch, 1'b1);
            check_eq("rd_addr", rd_addr, 4'd3);
         end
         check_eq("rd_miso", miso, (e >= 5) ? rval[12-e] : 1'b0);
         check_eq("rd_wr_en", wr_en, 1'b0);
      end
      drive(2'b01, 1'b0);
      check_eq("rd_miso_after", miso, 1'b0);
      check_eq("rd_busy_wait", busy, 1'b1);
      drive(2'b11, 1'b0);
      check_eq("rd_busy_fall", busy, 1'b0);
      check_eq("rd_err", frame_err, 1'b0);

      // Abort: cs_n rises at edge 8 of a write
      abits = {1'b1, 4'd7, 8'h5A};
      for (int e = 0; e <= 7; e++) begin
         drive(2'b10, abits[12-e]);
         check_eq("ab_wr_en", wr_en, 1'b0);
      end
      drive(2'b11, 1'b0);
      check_eq("ab_err", frame_err, 1'b1);
      check_eq("ab_busy", busy, 1'b0);
      check_eq("ab_wr_en_end", wr_en, 1'b0);
      drive(2'b11, 1'b0);
      check_eq("ab_err_pulse", frame_err, 1'b0);

      // Two selects low, then lock blocks a frame start
      drive(2'b00, 1'b1);
      check_eq("ms_err", frame_err, 1'b1);
      check_eq("ms_busy", busy, 1'b1);
      drive(2'b00, 1'b1);
      check_eq("ms_err_pulse", frame_err, 1'b0);
      check_eq("ms_wait", busy, 1'b1);
      drive(2'b11, 1'b0);
      check_eq("ms_busy_fall", busy, 1'b0);
      @(negedge clk);
      lock = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(2'b10, 1'b1);
         check_eq("lock_busy", busy, 1'b0);
         check_eq("lock_err", frame_err, 1'b0);
      end
      drive(2'b11, 1'b0);
      @(negedge clk);
      lock = 1'b0;

      // cs_n released on the final data edge still completes
      write_frame("rel", 2'b01, 1'b1, 4'd9, 8'h7E, 1'b1);

      // Address 15 with two data words
      bbits = {1'b1, 4'hF, 8'h11, 8'h22};
      for (int e = 0; e <= 20; e++) begin
         drive(2'b10, bbits[20-e]);
         check_eq("bu_wr_en", wr_en, (e == 12) || (BURST && e == 20));
         if (e == 12) begin
            check_eq("bu_addr0", wr_addr, 4'hF);
            check_eq("bu_data0", wr_data, 8'h11);
         end
      end
      check_eq("bu_addr1", wr_addr, BURST ? 4'h0 : 4'hF);
      check_eq("bu_data1", wr_data, BURST ? 8'h22 : 8'h11);
      check_eq("bu_busy", busy, 1'b1);
      drive(2'b11, 1'b0);
      check_eq("bu_busy_fall", busy, 1'b0);
      check_eq("bu_err", frame_err, 1'b0);

      // Reset at edge 6 of a write
      abits = {1'b1, 4'd6, 8'h99};
      for (int e = 0; e <= 5; e++) begin
         drive(2'b10, abits[12-e]);
      end
      @(negedge clk);
      rst = 1'b1;
      mosi = abits[6];
      @(posedge clk);
      #1;
      check_eq("mr_busy", busy, 1'b0);
      check_eq("mr_wr_en", wr_en, 1'b0);
      check_eq("mr_wr", {wr_ch, wr_addr, wr_data}, 13'h0);
      check_eq("mr_rd", {rd_en, rd_ch, rd_addr}, 6'h0);
      check_eq("mr_miso_err", {miso, frame_err}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      cs_n = 2'b11;
      for (int i = 0; i < 8; i++) begin
         drive(2'b11, 1'b1);
         check_eq("mr_no_strobe", wr_en, 1'b0);
      end
      write_frame("post", 2'b01, 1'b1, 4'd10, 8'h3C, 1'b0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/spi_mem_loader.md
# spi_mem_loader

Parametrised serial loader/readback port for the tiny processor's memories. It replaces the fixed 12-bit shift register and the receive states of the control FSM. It decodes bit-per-clock frames from the external master on one of NUM_CH chip selects into memory write strobes, and serves read frames back on miso. It sits between the uio pins and the icache/dcache write/read ports; the processor core drives `lock` while executing.

## Interface
Parameters:
- DATA_W, 8, memory word width in bits
- ADDR_W, 4, memory address width in bits (depth 2^ADDR_W)
- NUM_CH, 2, number of memory channels / chip selects (≥1); CH_W = max(1, clog2(NUM_CH))

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cs_n  in  NUM_CH  active-low chip selects, bit i selects channel i
- mosi  in  1  serial data, sampled on every posedge while a frame is active
- lock  in  1  high = no new frame may start (processor executing)
- miso  out  1  serial read data, MSB first
- wr_en  out  1  one-cycle write strobe
- wr_ch  out  CH_W  target channel of wr_en
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- rd_en  out  1  one-cycle read request
- rd_ch  out  CH_W  channel of rd_en
- rd_addr  out  ADDR_W  read address
- rd_data  in  DATA_W  combinational memory read data for rd_ch/rd_addr
- busy  out  1  high in any state other than IDLE
- frame_err  out  1  one-cycle error pulse

## Operation
- Frame format, edge index e counted from the first active posedge: e=0 command bit (1=write, 0=read); e=1..ADDR_W address, MSB first. For a write, e=ADDR_W+1..ADDR_W+DATA_W are data, MSB first. For a read, e=ADDR_W+1 is turnaround (mosi ignored), followed by DATA_W output cycles.
- States: IDLE, CMD, ADDR, WDATA, RTURN, RDATA, WAIT.
- IDLE: with lock=0 and exactly one cs_n bit low, latch the channel and consume the bit as e=0, going to ADDR. With more than one cs_n bit low, go to WAIT and pulse frame_err. With lock=1, stay in IDLE and ignore cs_n.
- ADDR: shift ADDR_W bits, then go to WDATA or RTURN according to the command bit.
- WDATA: shift DATA_W bits. wr_en=1 for one cycle with the latched ch/addr/data, then go to WAIT.
- RTURN: rd_en=1 with rd_ch/rd_addr. Capture rd_data into the output shift register at that posedge, then go to RDATA.
- RDATA: miso = shift register MSB, shifting left each cycle. After DATA_W cycles, go to WAIT.
- WAIT: ignore mosi; return to IDLE once all cs_n are high.
- Abort: if the latched channel's cs_n rises before the frame completes, discard the partial frame, issue no strobe, pulse frame_err for one cycle, and go to IDLE.
- Other cs_n bits changing mid-frame are ignored. lock rising mid-frame is ignored; the frame completes.
- miso is 0 outside RDATA.
- Bit counter width is clog2(ADDR_W+DATA_W+2). No arithmetic beyond the counter and the address increment (Configuration).

## Timing
- Reset: state IDLE. miso, wr_en, rd_en, busy, frame_err = 0. wr_ch, wr_addr, wr_data, rd_ch, rd_addr = 0.
- All outputs are registered except miso, which comes directly from the shift-register MSB (also registered).
- Write latency: wr_en is high in the cycle after edge ADDR_W+DATA_W.
- Read: rd_en is high in the cycle after edge ADDR_W. The first miso bit is valid in the cycle after edge ADDR_W+1. The last bit is valid in the cycle after edge ADDR_W+DATA_W.
- busy rises in the cycle after the e=0 edge and falls in the cycle after the return to IDLE.
- cs_n release on the same edge as the final data bit counts as complete: strobe issued, no error.
- rst mid-frame: immediate return to IDLE with outputs at reset values, and no strobe.

## Configuration
- SPI_MEM_LOADER_BURST_EN defined: after the first write word, WDATA continues while cs_n stays low. Each further DATA_W bits produce wr_en with wr_addr = base + n mod 2^ADDR_W, wrapping. A partial trailing word is discarded on cs_n release, with frame_err only if zero words were written. Read frames are unaffected.
- Not defined: bits after the first write word are ignored in WAIT, as described above.

## Test plan
All scenarios use DATA_W=8, ADDR_W=4, NUM_CH=2.
- Write frame on cs_n=2'b10 (channel 0): bits 1, 0101, 10100011 → one wr_en cycle after edge 12, with wr_ch=0, wr_addr=5, wr_data=0xA3. frame_err=0.
- Read frame on channel 1: bits 0, 0011, with rd_data tied to 0x5C → rd_en after edge 4 with rd_ch=1, rd_addr=3. miso is 0,1,0,1,1,1,0,0 over the cycles after edges 5..12.
- cs_n rises after edge 7 of a write → no wr_en, frame_err one cycle, busy falls.
- cs_n=2'b00 in IDLE → frame_err pulse and WAIT until 2'b11. Then lock=1 with cs_n=2'b10 → busy stays 0.
- With SPI_MEM_LOADER_BURST_EN: write to addr 15 carrying 0x11, 0x22 → wr_addr=15 (0x11) then wr_addr=0 (0x22), strobes 8 cycles apart.
- rst asserted at edge 6 of a write → all outputs 0 next cycle, no wr_en. A following clean frame behaves normally.
